// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the E stage.
// Launches on a one-cycle start, holds busy for the whole operation and
// commits the result to HI/LO on the last busy cycle.
// Optional feature macro: MD_ITER_DIV_EN selects a 33-cycle radix-2
// restoring divider instead of the behavioural divider with DIV_CYCLES delay.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic        sel_lo,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpMfhi  = 3'd5;
  localparam logic [2:0] OpMflo  = 3'd6;
  localparam logic [2:0] OpMt    = 3'd7;

`ifdef MD_ITER_DIV_EN
  localparam int unsigned DivLat = 33;
`else
  localparam int unsigned DivLat = DIV_CYCLES;
`endif

  typedef enum logic {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_mult;
  logic        div_signed;
  logic [63:0] ext_a, ext_b, prod;
  logic [31:0] a_mag, b_mag;
  logic [31:0] quo_mag, rem_mag;
  logic [31:0] quo_fix, rem_fix;
  logic        quo_neg, rem_neg;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  // Product and sign-corrected quotient/remainder from the captured operands.
  always_comb begin
    is_mult    = (op_q == OpMult) || (op_q == OpMultu);
    div_signed = (op_q == OpDiv);
    ext_a      = (op_q == OpMult) ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    ext_b      = (op_q == OpMult) ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod       = ext_a * ext_b;
    a_mag      = mag(a_q, div_signed);
    b_mag      = mag(b_q, div_signed);
    quo_neg    = div_signed && (a_q[31] ^ b_q[31]);
    rem_neg    = div_signed && a_q[31];
    quo_fix    = quo_neg ? (~quo_mag + 32'd1) : quo_mag;
    rem_fix    = rem_neg ? (~rem_mag + 32'd1) : rem_mag;
  end

`ifdef MD_ITER_DIV_EN
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dmag_q, dmag_d;
  logic [32:0] r_sh;
  logic [32:0] r_sub;
  logic [31:0] rem_n, quo_n;
  logic        qbit;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    r_sh  = {rem_q, quo_q[31]};
    r_sub = r_sh - {1'b0, dmag_q};
    qbit  = (r_sh >= {1'b0, dmag_q});
    rem_n = qbit ? r_sub[31:0] : r_sh[31:0];
    quo_n = {quo_q[30:0], qbit};
  end

  // Setup on the first busy cycle, then 32 iterations; the last one commits.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dmag_d = dmag_q;
    if (state_q == StRun && !is_mult) begin
      if (cnt_q == 32'd33) begin
        rem_d  = 32'd0;
        quo_d  = a_mag;
        dmag_d = b_mag;
      end else begin
        rem_d = rem_n;
        quo_d = quo_n;
      end
    end
  end

  // Divider datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dmag_q <= 32'd0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dmag_q <= dmag_d;
    end
  end

  assign quo_mag = quo_n;
  assign rem_mag = rem_n;
`else
  // Behavioural divide on magnitudes; the zero guard keeps X out of the result.
  always_comb begin
    quo_mag = 32'd0;
    rem_mag = 32'd0;
    if (b_mag != 32'd0) begin
      quo_mag = a_mag / b_mag;
      rem_mag = a_mag % b_mag;
    end
  end
`endif

  // Next-state: launch, count down, commit on the last cycle, MT* writes in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          op_d    = md_op;
          cnt_d   = ((md_op == OpMult) || (md_op == OpMultu)) ? MULT_CYCLES : DivLat;
          state_d = StRun;
        end else if (md_op == OpMt) begin
          if (sel_lo) begin
            lo_d = A;
          end else begin
            hi_d = A;
          end
        end
      end
      StRun: begin
        cnt_d = cnt_q - 32'd1;
        if (cnt_q == 32'd1) begin
          state_d = StIdle;
          if (is_mult) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, operand and HI/LO registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 3'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Outputs and combinational MF* read port.
  always_comb begin
    busy   = (state_q == StRun);
    hi     = hi_q;
    lo     = lo_q;
    md_out = 32'd0;
    if (md_op == OpMfhi) begin
      md_out = hi_q;
    end else if (md_op == OpMflo) begin
      md_out = lo_q;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit with hand-computed vectors.
module tb_md_unit;

`ifdef MD_ITER_DIV_EN
  localparam int DivN = 33;
`else
  localparam int DivN = 10;
`endif
  localparam int MultN = 5;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  md_op;
  logic        sel_lo;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int checks = 0;
  int errors = 0;

  md_unit #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .md_op  (md_op),
    .sel_lo (sel_lo),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo),
    .md_out (md_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch in cycle T, scramble operands afterwards, check busy over T+1..T+n
  // and leave the bench in cycle T+n+1 with busy expected low.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n);
    md_op = op;
    A     = a;
    B     = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    md_op = 3'd0;
    A     = 32'h5A5A_A5A5;
    B     = 32'h0000_0007;
    for (int k = 1; k <= n; k++) begin
      check({tag, " busy"}, {31'd0, busy}, 32'd1);
      tick();
    end
    check({tag, " done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    md_op   = 3'd0;
    sel_lo  = 1'b0;
    A       = 32'd0;
    B       = 32'd0;
    tick();
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst hi", hi, 32'd0);
    check("rst lo", lo, 32'd0);
    check("rst md_out", md_out, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1. Signed multiply -2 * 3
    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, MultN);
    check("mult hi", hi, 32'hFFFF_FFFF);
    check("mult lo", lo, 32'hFFFF_FFFA);
    md_op = 3'd5;
    #1;
    check("mfhi", md_out, 32'hFFFF_FFFF);
    md_op = 3'd0;
    #1;
    check("md_out none", md_out, 32'd0);

    // 2. Unsigned multiply
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, MultN);
    check("multu hi", hi, 32'h0000_0001);
    check("multu lo", lo, 32'hFFFF_FFFE);

    // 3. Signed divides
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, DivN);
    check("div lo", lo, 32'hFFFF_FFFD);
    check("div hi", hi, 32'hFFFF_FFFF);
    run_op("div2", 3'd3, 32'd7, 32'hFFFF_FFFE, DivN);
    check("div2 lo", lo, 32'hFFFF_FFFD);
    check("div2 hi", hi, 32'h0000_0001);
    run_op("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DivN);
    check("divovf lo", lo, 32'h8000_0000);
    check("divovf hi", hi, 32'h0000_0000);
    run_op("divu", 3'd4, 32'hFFFF_FFF9, 32'd16, DivN);
    check("divu lo", lo, 32'h0FFF_FFFF);
    check("divu hi", hi, 32'h0000_0009);

    // 4. MTLO/MTHI then divide by zero leaves HI/LO alone
    md_op  = 3'd7;
    sel_lo = 1'b1;
    A      = 32'h0000_1234;
    tick();
    check("mtlo", lo, 32'h0000_1234);
    sel_lo = 1'b0;
    A      = 32'h0000_ABCD;
    tick();
    check("mthi", hi, 32'h0000_ABCD);
    check("mthi lo kept", lo, 32'h0000_1234);
    md_op = 3'd0;
    run_op("divz", 3'd4, 32'd5, 32'd0, DivN);
    check("divz lo", lo, 32'h0000_1234);
    check("divz hi", hi, 32'h0000_ABCD);
    md_op = 3'd6;
    #1;
    check("mflo", md_out, 32'h0000_1234);
    md_op = 3'd0;

    // 5. Reset in the middle of a multiply
    md_op = 3'd1;
    A     = 32'd2;
    B     = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    md_op = 3'd0;
    tick();
    tick();
    check("pre-rst busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst hi", hi, 32'd0);
    check("midrst lo", lo, 32'd0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    check("postrst busy", {31'd0, busy}, 32'd0);
    check("postrst hi", hi, 32'd0);
    check("postrst lo", lo, 32'd0);

    // 6. Second start and MTHI while running are ignored
    md_op = 3'd1;
    A     = 32'd4;
    B     = 32'd5;
    start = 1'b1;
    tick();
    A = 32'd100;
    B = 32'd100;
    tick();
    start  = 1'b0;
    md_op  = 3'd7;
    sel_lo = 1'b0;
    A      = 32'h0000_DEAD;
    tick();
    check("run mthi ignored", hi, 32'd0);
    md_op = 3'd5;
    #1;
    check("run mfhi old", md_out, 32'd0);
    md_op = 3'd0;
    tick();
    tick();
    check("coll busy T+5", {31'd0, busy}, 32'd1);
    tick();
    check("coll busy T+6", {31'd0, busy}, 32'd0);
    check("coll hi", hi, 32'd0);
    check("coll lo", lo, 32'd20);
    for (int k = 0; k < 6; k++) tick();
    check("coll no 2nd", lo, 32'd20);
    check("coll idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
